// File: rtl/accel_axis_scanner_if.sv
// SPI link between accel_axis_scanner (master) and the accelerometer (slave).
interface accel_axis_scanner_if;
    logic CS;
    logic SCLK;
    logic SDO;
    logic SDI;

    modport master (output CS, output SCLK, output SDO, input SDI);
    modport slave  (input CS, input SCLK, input SDO, output SDI);
endinterface

// File: rtl/accel_axis_scanner.sv
// Periodic SPI mode-0 burst reader for a multi-axis accelerometer.
// Define ACCEL_INIT_EN to send a measurement-mode write frame after every reset.
module accel_axis_scanner #(
    parameter int unsigned CLK_DIV       = 50,
    parameter int unsigned NUM_AXES      = 3,
    parameter logic [7:0]  START_ADDR    = 8'h0E,
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    accel_axis_scanner_if.master   spi,
    output logic [16*NUM_AXES-1:0] axis_value,
    output logic                   valid
);
    localparam int unsigned NBITS      = 8 * (2 + 2 * NUM_AXES);
    localparam int unsigned DATA_BYTES = 2 * NUM_AXES;
    localparam int unsigned DATA_W     = 16 * NUM_AXES;
    localparam int unsigned INIT_BITS  = 24;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W      = $clog2(NBITS);
    localparam int unsigned PER_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [NBITS-1:0] RD_FRAME   = {8'h0B, START_ADDR, {(NBITS-16){1'b0}}};
    localparam logic [NBITS-1:0] INIT_FRAME = {24'h0A2D02, {(NBITS-INIT_BITS){1'b0}}};
    localparam logic [BIT_W-1:0] LAST_RD    = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0] LAST_INIT  = BIT_W'(INIT_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state_q;
    logic [PER_W-1:0]  per_q;
    logic              pend_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [NBITS-1:0]  tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] axis_q;
    logic [DATA_W-1:0] axis_d;
    logic              cs_q;
    logic              sclk_q;
    logic              sdo_q;
    logic              valid_q;
    logic              init_q;

    logic wrap;
    logic div_end;
    logic last_bit;
    logic frame_ok;
    logic start_init;
    logic start_rd;
    logic [NBITS-1:0] frame_sel;

    assign wrap     = (per_q == PER_W'(SAMPLE_PERIOD - 1));
    assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_q == (init_q ? LAST_INIT : LAST_RD));
    // Launching from the final GAP cycle is the IDLE->SETUP step without a dead
    // IDLE cycle, so back-to-back frames keep CS high for exactly CLK_DIV cycles.
    assign frame_ok = (state_q == IDLE) || ((state_q == GAP) && div_end);

`ifdef ACCEL_INIT_EN
    logic init_pend_q;
    assign start_init = frame_ok && init_pend_q;
`else
    assign start_init = 1'b0;
`endif
    assign start_rd  = frame_ok && !start_init && pend_q && en;
    assign frame_sel = start_init ? INIT_FRAME : RD_FRAME;

    // Data byte k sits at rx_q[8*(DATA_BYTES-1-k) +: 8]; axis i = {byte 2i+1, byte 2i}.
    always_comb begin
        axis_d = '0;
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            axis_d[16*i +: 8]   = rx_q[8*(DATA_BYTES-1-2*i) +: 8];
            axis_d[16*i+8 +: 8] = rx_q[8*(DATA_BYTES-2-2*i) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            per_q   <= '0;
            pend_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            axis_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
`ifdef ACCEL_INIT_EN
            init_pend_q <= 1'b1;
`endif
        end else begin
            valid_q <= 1'b0;
            per_q   <= wrap ? '0 : per_q + 1'b1;
            if (start_rd) begin
                pend_q <= wrap;
            end else if (wrap) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                SETUP: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end && !sclk_q) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[DATA_W-2:0], spi.SDI};
                    end else if (div_end) begin
                        sclk_q <= 1'b0;
                        if (last_bit) begin
                            state_q <= HOLD;
                            sdo_q   <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            sdo_q <= tx_q[NBITS-1];
                            tx_q  <= tx_q << 1;
                        end
                    end
                end
                HOLD: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        state_q <= GAP;
                        cs_q    <= 1'b1;
                        if (!init_q) begin
                            axis_q  <= axis_d;
                            valid_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    div_q <= '0;
                end
            endcase

            if (start_init || start_rd) begin
                state_q <= SETUP;
                cs_q    <= 1'b0;
                sclk_q  <= 1'b0;
                div_q   <= '0;
                bit_q   <= '0;
                sdo_q   <= frame_sel[NBITS-1];
                tx_q    <= frame_sel << 1;
                init_q  <= start_init;
`ifdef ACCEL_INIT_EN
                init_pend_q <= 1'b0;
`endif
            end
        end
    end

    assign spi.CS     = cs_q;
    assign spi.SCLK   = sclk_q;
    assign spi.SDO    = sdo_q;
    assign axis_value = axis_q;
    assign valid      = valid_q;
endmodule

// File: tb/tb_accel_axis_scanner.sv
// Directed bench for accel_axis_scanner: read frame contents/timing, en gating,
// mid-frame reset and back-to-back framing (second instance, SAMPLE_PERIOD=10).
module tb_accel_axis_scanner;
`ifdef ACCEL_INIT_EN
    localparam int INIT_FR = 1;
`else
    localparam int INIT_FR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reset_b;
    logic        en;
    logic        en_b = 1'b1;
    logic [47:0] axis_a;
    logic [47:0] axis_b;
    logic        valid_a;
    logic        valid_b;

    accel_axis_scanner_if spi_a ();
    accel_axis_scanner_if spi_b ();

    assign spi_b.SDI = 1'b0;

    accel_axis_scanner #(
        .CLK_DIV(2), .NUM_AXES(3), .START_ADDR(8'h0E), .SAMPLE_PERIOD(400)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .spi(spi_a),
        .axis_value(axis_a), .valid(valid_a)
    );

    accel_axis_scanner #(
        .CLK_DIV(2), .NUM_AXES(3), .START_ADDR(8'h0E), .SAMPLE_PERIOD(10)
    ) dut_b2b (
        .clk(clk), .reset(reset_b), .en(en_b), .spi(spi_b),
        .axis_value(axis_b), .valid(valid_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sensor model and bus monitor for instance A
    logic [63:0] miso_data = '0;
    logic [63:0] miso_sh   = '0;
    logic [63:0] mosi      = '0;
    logic [63:0] last_mosi = '0;
    logic cs_prev = 1'b1, sclk_prev = 1'b0;
    int cyc = 0, cs_run = 0, rise_cnt = 0, last_rise = 0;
    int per_min = 0, per_max = 0, last_per_min = 0, last_per_max = 0;
    int last_bits = 0, last_cs_low = 0, frames_done = 0;
    int valid_cnt = 0, valid_at_rise = 0, idle_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (spi_a.CS && spi_a.SCLK) idle_bad++;
        if (valid_a) valid_cnt++;
        if (!spi_a.CS && cs_prev) begin
            cs_run = 0; rise_cnt = 0; per_min = 1000; per_max = 0; mosi = '0;
            miso_sh = miso_data;
            spi_a.SDI = miso_sh[63];
        end
        if (!spi_a.CS) cs_run++;
        if (!spi_a.CS && spi_a.SCLK && !sclk_prev) begin
            if (rise_cnt > 0) begin
                if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
            rise_cnt++;
            mosi = {mosi[62:0], spi_a.SDO};
        end
        if (!spi_a.CS && !spi_a.SCLK && sclk_prev) begin
            miso_sh = miso_sh << 1;
            spi_a.SDI = miso_sh[63];
        end
        if (spi_a.CS && !cs_prev) begin
            last_cs_low = cs_run; last_bits = rise_cnt; last_mosi = mosi;
            last_per_min = per_min; last_per_max = per_max;
            frames_done++;
            if (valid_a) valid_at_rise++;
        end
        cs_prev = spi_a.CS;
        sclk_prev = spi_a.SCLK;
    end

    // Monitor for the back-to-back instance
    logic csb_prev = 1'b1;
    int frames_b = 0, valid_b_cnt = 0, hi_run = 0, gap_min = 1000, gap_max = 0;

    always @(negedge clk) begin
        if (!reset_b) begin
            if (valid_b) valid_b_cnt++;
            if (spi_b.CS && !csb_prev) begin
                frames_b++;
                hi_run = 0;
            end
            if (spi_b.CS) hi_run++;
            if (!spi_b.CS && csb_prev && frames_b > 0) begin
                if (hi_run < gap_min) gap_min = hi_run;
                if (hi_run > gap_max) gap_max = hi_run;
            end
        end
        csb_prev = spi_b.CS;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(frames_done >= target), 64'd1);
    endtask

    int t0, cs_act, lat, base, n;

    initial begin
        reset = 1'b1; reset_b = 1'b1; en = 1'b0;
        miso_data = 64'h0000_3412_7856_BC9A;
        repeat (4) tick();
        check("rst_cs",    64'(spi_a.CS),   64'd1);
        check("rst_sclk",  64'(spi_a.SCLK), 64'd0);
        check("rst_sdo",   64'(spi_a.SDO),  64'd0);
        check("rst_valid", 64'(valid_a),    64'd0);
        check("rst_axis",  64'(axis_a),     64'd0);

        reset = 1'b0; reset_b = 1'b0;
        t0 = cyc;
`ifdef ACCEL_INIT_EN
        wait_frames(1, 600, "init_done");
        check("init_bits",  64'(last_bits), 64'd24);
        check("init_sdo",   last_mosi,       64'h0A2D02);
        check("init_valid", 64'(valid_cnt), 64'd0);
        check("init_axis",  64'(axis_a),    64'd0);
`endif
        cs_act = 0;
        while (cyc - t0 < 1000) begin
            tick();
            if (!spi_a.CS) cs_act++;
        end
        check("no_cs_while_en_low", 64'(cs_act), 64'd0);

        base = frames_done;
        en = 1'b1;
        lat = 0;
        while (spi_a.CS && lat < 10) begin
            tick();
            lat++;
        end
        check("en_start_lat", 64'(lat), 64'd1);

        wait_frames(base + 1, 400, "frame1_done");
        check("f1_cs_low",     64'(last_cs_low),   64'd260);
        check("f1_bits",       64'(last_bits),     64'd64);
        check("f1_sdo",        last_mosi,          64'h0B0E_0000_0000_0000);
        check("f1_sclk_min",   64'(last_per_min),  64'd4);
        check("f1_sclk_max",   64'(last_per_max),  64'd4);
        check("f1_valid_cnt",  64'(valid_cnt),     64'd1);
        check("f1_valid_rise", 64'(valid_at_rise), 64'd1);
        check("f1_axis",       64'(axis_a),        64'h9ABC_5678_1234);

        // Second frame: reset while bit 20 is on the wire
        n = 0;
        while (spi_a.CS && n < 1000) begin
            tick();
            n++;
        end
        tick();
        while (rise_cnt < 21 && n < 2000) begin
            tick();
            n++;
        end
        check("f2_reached_bit20", 64'(rise_cnt), 64'd21);
        reset = 1'b1;
        tick();
        check("abort_cs",    64'(spi_a.CS),   64'd1);
        check("abort_sclk",  64'(spi_a.SCLK), 64'd0);
        check("abort_valid", 64'(valid_a),    64'd0);
        check("abort_axis",  64'(axis_a),     64'd0);
        repeat (3) tick();
        check("abort_no_pulse", 64'(valid_cnt), 64'd1);

        miso_data = 64'h0000_1122_3344_5566;
        reset = 1'b0;
`ifdef ACCEL_INIT_EN
        base = frames_done;
        wait_frames(base + 1, 600, "init2_done");
`else
        lat = 0;
        while (spi_a.CS && lat < 1000) begin
            tick();
            lat++;
        end
        check("first_start_lat", 64'(lat), 64'd401);
`endif
        base = frames_done;
        wait_frames(base + 1, 800, "frame3_done");
        check("f3_axis",      64'(axis_a),      64'h6655_4433_2211);
        check("f3_cs_low",    64'(last_cs_low), 64'd260);
        check("f3_valid_cnt", 64'(valid_cnt),   64'd2);
        check("sclk_idle_low", 64'(idle_bad),   64'd0);

        check("b2b_enough_frames", 64'(frames_b >= 5), 64'd1);
        check("b2b_gap_min",   64'(gap_min),     64'd2);
        check("b2b_gap_max",   64'(gap_max),     64'd2);
        check("b2b_valid_cnt", 64'(valid_b_cnt), 64'(frames_b - INIT_FR));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
